sys_arr_cell_dbuf: RTL

//  Next-generation systolic-array cell with double-buffered stationary weights.
//  - Weights for the next tile load into a shadow register while the current

---
 rtl/proc_pipe_pckg.sv | 18 +
 rtl/del_chain.sv | 34 +++
 rtl/sys_arr_cell_dbuf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/proc_pipe_pckg.sv
// Shared definitions for the systolic-array processing pipeline: beat type encoding,
// an all-zero beat constant and the type legality check.
package proc_pipe_pckg;

    typedef enum logic [1:0] {
        TYPE_DATA        = 2'd0,
        TYPE_STAT_WEIGHT = 2'd1
    } data_type_e;

    // Wide enough for any beat or product payload; users slice the width they need.
    localparam int MAX_BEAT_WDT = 132;
    localparam logic [MAX_BEAT_WDT-1:0] ZERO_BEAT = '0;

    function automatic logic type_legal(input logic [1:0] t);
        return (t == TYPE_DATA) || (t == TYPE_STAT_WEIGHT);
    endfunction

endpackage

// File: rtl/del_chain.sv
// Enable-gated delay line of LAT register stages; LAT=0 degenerates to a wire.
module del_chain #(
    parameter int WDT = 8,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [WDT-1:0] d_i,
    output logic [WDT-1:0] q_o
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WDT-1:0] stage_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
                end else if (en) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sys_arr_cell_dbuf.sv
// Systolic-array cell with double-buffered stationary weight: a shadow weight loads
// during the current tile and swaps into the active slot after the tile's last beat.
module sys_arr_cell_dbuf
    import proc_pipe_pckg::*;
#(
    parameter int DATA_WDT = 8,
    parameter int CNT_MAX  = 0,
    parameter int CNT_WDT  = 4,
    parameter int FORW_LAT = 1,
    parameter int MULT_LAT = 2,
    parameter bit SIGNED   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [DATA_WDT-1:0]   l_data,
    input  logic                  l_val,
    input  logic [1:0]            l_type,
    input  logic                  l_last,
    output logic [DATA_WDT-1:0]   r_data,
    output logic                  r_val,
    output logic [1:0]            r_type,
    output logic                  r_last,
    output logic [2*DATA_WDT-1:0] prod,
    output logic                  prod_val,
    output logic                  shadow_full,
    output logic                  err_ovf,
    output logic                  err_type
);

    localparam int FW = DATA_WDT + 4;
    localparam int PW = 2 * DATA_WDT + 1;
    localparam logic [CNT_WDT-1:0] CNT_LAST = CNT_WDT'(CNT_MAX);

    logic [DATA_WDT-1:0] act_q, act_d, sh_q, sh_d;
    logic                act_val_q, act_val_d, sh_val_q, sh_val_d;
    logic [CNT_WDT-1:0]  cnt_q, cnt_d;
    logic                err_ovf_q, err_ovf_d, err_type_q, err_type_d;
    logic [PW-1:0]       mul_q, mul_d;
    logic                is_data, is_wgt, is_cap;
    logic [FW-1:0]       fwd_beat, fwd_out;
    logic [PW-1:0]       prod_out;

    logic signed [2*DATA_WDT-1:0] prod_s;
    logic        [2*DATA_WDT-1:0] prod_u, prod_sel;

    // Signed product is kept in its own signal so the ternary below cannot
    // strip the signedness from the multiply operands.
    assign prod_s   = $signed(act_q) * $signed(l_data);
    assign prod_u   = {{DATA_WDT{1'b0}}, act_q} * {{DATA_WDT{1'b0}}, l_data};
    assign prod_sel = SIGNED ? $unsigned(prod_s) : prod_u;

    always_comb begin
        is_data    = l_val && (l_type == TYPE_DATA);
        is_wgt     = l_val && (l_type == TYPE_STAT_WEIGHT);
        is_cap     = is_wgt && (cnt_q == CNT_LAST);
        act_d      = act_q;
        act_val_d  = act_val_q;
        sh_d       = sh_q;
        sh_val_d   = sh_val_q;
        cnt_d      = cnt_q;
        err_ovf_d  = err_ovf_q;
        err_type_d = err_type_q;
        fwd_beat   = ZERO_BEAT[FW-1:0];
        mul_d      = ZERO_BEAT[PW-1:0];

        if (is_data) begin
            fwd_beat = {1'b1, l_type, l_last, l_data};
            mul_d    = {1'b1, act_val_q ? prod_sel : {2*DATA_WDT{1'b0}}};
            // The last beat still multiplies against the old weight; swap takes effect after it.
            if (l_last) begin
                act_d     = sh_q;
                act_val_d = sh_val_q;
                sh_val_d  = 1'b0;
            end
        end

        if (is_wgt) begin
            if (is_cap) begin
                sh_d     = l_data;
                sh_val_d = 1'b1;
                cnt_d    = '0;
                if (sh_val_q) err_ovf_d = 1'b1;
            end else begin
                cnt_d    = cnt_q + 1'b1;
                fwd_beat = {1'b1, l_type, l_last, l_data};
            end
        end

        if (l_val && !type_legal(l_type)) err_type_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= '0;
            act_val_q  <= 1'b0;
            sh_q       <= '0;
            sh_val_q   <= 1'b0;
            cnt_q      <= '0;
            err_ovf_q  <= 1'b0;
            err_type_q <= 1'b0;
            mul_q      <= '0;
        end else if (clk_en) begin
            act_q      <= act_d;
            act_val_q  <= act_val_d;
            sh_q       <= sh_d;
            sh_val_q   <= sh_val_d;
            cnt_q      <= cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_type_q <= err_type_d;
            mul_q      <= mul_d;
        end
    end

    del_chain #(.WDT(FW), .LAT(FORW_LAT)) u_fwd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (clk_en),
        .d_i   (fwd_beat),
        .q_o   (fwd_out)
    );

    del_chain #(.WDT(PW), .LAT(MULT_LAT - 1)) u_prod_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (clk_en),
        .d_i   (mul_q),
        .q_o   (prod_out)
    );

    assign {r_val, r_type, r_last, r_data} = fwd_out;
    assign {prod_val, prod}                = prod_out;
    assign shadow_full                     = sh_val_q;
    assign err_ovf                         = err_ovf_q;
    assign err_type                        = err_type_q;

endmodule
